// File: rtl/mpsoc_mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
// Build option: define MPSOC_MEM_ARB_RR_EN for round-robin contention
// resolution. Without it, master 0 has fixed priority.
package mpsoc_mem_arb_pkg;

  // One bit is enough to name either master.
  typedef logic master_id_t;

  localparam int NUM_MASTERS = 2;

  localparam master_id_t MASTER_0 = 1'b0;
  localparam master_id_t MASTER_1 = 1'b1;

  localparam int DEFAULT_ADDR_W   = 11;
  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_HOLD_MAX = 4;

  // Returns the master that is not 'id'.
  function automatic master_id_t other_master(input master_id_t id);
    return ~id;
  endfunction

  // Returns the one-hot grant vector that selects master 'id'.
  function automatic logic [NUM_MASTERS-1:0] onehot_of(input master_id_t id);
    return (id == MASTER_1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mpsoc_arb_grant.sv
// Grant logic for the two-master memory arbiter.
// Produces a one-hot grant each cycle from the current requests, the last
// granted master and the consecutive-grant counter. Policy is selected by
// MPSOC_MEM_ARB_RR_EN (round-robin when defined, master 0 priority when not).
// In both policies a master that has held the memory for HOLD_MAX issues
// while the other master waits gives way.
module mpsoc_arb_grant
  import mpsoc_mem_arb_pkg::*;
#(
  parameter int HOLD_MAX = DEFAULT_HOLD_MAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req,
  output logic [NUM_MASTERS-1:0] grant
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_MAX);

  master_id_t       last_grant;
  logic [CNT_W-1:0] hold_cnt;
  master_id_t       granted_id;
  logic             hold_expired;

  assign granted_id   = grant[1];
  assign hold_expired = (hold_cnt == HOLD_LIMIT);

  // Choose which master owns the memory this cycle; nobody owns it in reset.
  always_comb begin
    grant = '0;
    if (!reset) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
          if (hold_expired) begin
            grant = onehot_of(other_master(last_grant));
          end else begin
`ifdef MPSOC_MEM_ARB_RR_EN
            grant = onehot_of(other_master(last_grant));
`else
            grant = onehot_of(MASTER_0);
`endif
          end
        end
        default: grant = '0;
      endcase
    end
  end

  // Track who issued last and how many issues in a row it has made; the
  // counter saturates so a lone requester never wraps it back below the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= MASTER_1;
      hold_cnt   <= '0;
    end else if (grant == '0) begin
      hold_cnt <= '0;
    end else if (granted_id == last_grant) begin
      if (!hold_expired) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
    end else begin
      last_grant <= granted_id;
      hold_cnt   <= CNT_W'(1);
    end
  end

endmodule

// File: rtl/mpsoc_mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Each cycle at most one master is granted and its command goes straight to
// the RAM. Reads return one cycle later and are routed back to the issuing
// master through a one-entry tag. Define MPSOC_MEM_ARB_RR_EN for
// round-robin arbitration; the default build uses master 0 priority.
module mpsoc_mem_arbiter
  import mpsoc_mem_arb_pkg::*;
#(
  parameter  int ADDR_W   = DEFAULT_ADDR_W,
  parameter  int DATA_W   = DEFAULT_DATA_W,
  parameter  int HOLD_MAX = DEFAULT_HOLD_MAX,
  localparam int BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  output logic              m0_waitrequest,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              m1_waitrequest,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic                   read_issue;
  logic                   rd_valid;
  master_id_t             rd_id;

  // A write wins over a read presented in the same cycle.
  assign req = {m1_read | m1_write, m0_read | m0_write};

  mpsoc_arb_grant #(
    .HOLD_MAX (HOLD_MAX)
  ) u_grant (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  // Steer the granted master's command onto the RAM port.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = 1'b0;
    read_issue     = 1'b0;
    if (grant[1]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
      read_issue     = m1_read & ~m1_write;
    end else if (grant[0]) begin
      mem_write      = m0_write;
      read_issue     = m0_read & ~m0_write;
    end
  end

  assign mem_chipselect = |grant;
  assign mem_clken      = ~reset;

  // Stall every master during reset; otherwise only a requester that lost.
  always_comb begin
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (!reset) begin
      m0_waitrequest = req[0] & ~grant[0];
      m1_waitrequest = req[1] & ~grant[1];
    end
  end

  // Remember for exactly one cycle which master owns the read data in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_id    <= MASTER_0;
    end else begin
      rd_valid <= read_issue;
      rd_id    <= grant[1];
    end
  end

  // Both masters see the RAM data; only the tagged one sees it as valid.
  always_comb begin
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
    m0_readdatavalid = ~reset & rd_valid & (rd_id == MASTER_0);
    m1_readdatavalid = ~reset & rd_valid & (rd_id == MASTER_1);
  end

endmodule

// File: tb/tb_mpsoc_mem_arbiter.sv
// Directed self-checking bench for mpsoc_mem_arbiter with a behavioural
// single-port RAM (one-cycle read latency, byte-enabled writes).
// Expected grant patterns follow MPSOC_MEM_ARB_RR_EN when it is defined.
module tb_mpsoc_mem_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] m0_address;
  logic [BE_W-1:0]   m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  logic              m0_waitrequest;
  logic [ADDR_W-1:0] m1_address;
  logic [BE_W-1:0]   m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  logic              m1_waitrequest;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int tests_run;
  int tests_failed;

  mpsoc_mem_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .HOLD_MAX (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m0_waitrequest   (m0_waitrequest),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .m1_waitrequest   (m1_waitrequest),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: byte-enabled write, registered read data.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++) begin
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m0_read = 1'b0; m0_write = 1'b0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    m0_read = 1'b1;
    m1_write = 1'b1;
    #2;
    tests_run++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_waitrequest: got m0=%b m1=%b, expected 1 1", m0_waitrequest, m1_waitrequest);
    end
    tests_run++;
    if (mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mem_ctrl: got cs=%b wr=%b clken=%b, expected 0 0 0", mem_chipselect, mem_write, mem_clken);
    end
    step();
    step();
    drive_idle();
    #2;
    tests_run++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_rdv: got m0=%b m1=%b, expected 0 0", m0_readdatavalid, m1_readdatavalid);
    end
    step();
    reset = 1'b0;
    #2;
    tests_run++;
    if (mem_clken !== 1'b1 || mem_chipselect !== 1'b0 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_idle: got clken=%b cs=%b w0=%b w1=%b, expected 1 0 0 0",
               mem_clken, mem_chipselect, m0_waitrequest, m1_waitrequest);
    end
  endtask

  task automatic test_write_read();
    step();
    m0_write = 1'b1; m0_address = 11'h005; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
    #2;
    tests_run++;
    if (mem_chipselect !== 1'b1 || mem_write !== 1'b1 || mem_address !== 11'h005 ||
        mem_writedata !== 32'hDEADBEEF || m0_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL m0_write_cmd: got cs=%b wr=%b addr=%h data=%h w0=%b, expected 1 1 005 deadbeef 0",
               mem_chipselect, mem_write, mem_address, mem_writedata, m0_waitrequest);
    end
    step();
    m0_write = 1'b0; m0_read = 1'b1;
    #2;
    tests_run++;
    if (mem_chipselect !== 1'b1 || mem_write !== 1'b0 || m0_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL m0_read_cmd: got cs=%b wr=%b rdv=%b, expected 1 0 0", mem_chipselect, mem_write, m0_readdatavalid);
    end
    step();
    drive_idle();
    #2;
    tests_run++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || m1_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL m0_read_return: got rdv0=%b data=%h rdv1=%b, expected 1 deadbeef 0",
               m0_readdatavalid, m0_readdata, m1_readdatavalid);
    end
    step();
    #2;
    tests_run++;
    if (m0_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL m0_rdv_one_cycle: got %b, expected 0", m0_readdatavalid);
    end
  endtask

  task automatic test_partial_write();
    step();
    m1_write = 1'b1; m1_address = 11'h7FF; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
    step();
    m1_writedata = 32'h0000ABCD; m1_byteenable = 4'h3;
    #2;
    tests_run++;
    if (mem_address !== 11'h7FF || mem_byteenable !== 4'h3 || m1_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL m1_partial_cmd: got addr=%h be=%h w1=%b, expected 7ff 3 0", mem_address, mem_byteenable, m1_waitrequest);
    end
    step();
    m1_write = 1'b0; m1_read = 1'b1;
    step();
    drive_idle();
    #2;
    tests_run++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hFFFFABCD || m0_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL m1_partial_return: got rdv1=%b data=%h rdv0=%b, expected 1 ffffabcd 0",
               m1_readdatavalid, m1_readdata, m0_readdatavalid);
    end
  endtask

  task automatic test_single_master();
    int stalls;
    stalls = 0;
    step();
    m1_read = 1'b1; m1_address = 11'h7FF;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (m1_waitrequest !== 1'b0) stalls++;
      step();
    end
    drive_idle();
    tests_run++;
    if (stalls != 0) begin
      tests_failed++;
      $display("[TB] FAIL lone_master_stalls: got %0d stalled cycles, expected 0", stalls);
    end
    step();
  endtask

  task automatic test_contention();
    logic exp_g1;
    logic prev_g1;
    int   run;
    int   max_run;
    int   errs;
    run = 0; max_run = 0; errs = 0; prev_g1 = 1'b0;
    m0_read = 1'b1; m0_address = 11'h005;
    m1_read = 1'b1; m1_address = 11'h7FF;
    for (int i = 0; i < 15; i++) begin
      #2;
`ifdef MPSOC_MEM_ARB_RR_EN
      exp_g1 = (i % 2) == 1;
`else
      exp_g1 = (i % 5) == 4;
`endif
      tests_run++;
      if (m0_waitrequest !== exp_g1 || m1_waitrequest !== !exp_g1 || mem_address !== (exp_g1 ? 11'h7FF : 11'h005)) begin
        tests_failed++; errs++;
        $display("[TB] FAIL contention_grant[%0d]: got w0=%b w1=%b addr=%h, expected w0=%b w1=%b",
                 i, m0_waitrequest, m1_waitrequest, mem_address, exp_g1, !exp_g1);
      end
      if (i > 0) begin
        tests_run++;
        if (m0_readdatavalid !== !prev_g1 || m1_readdatavalid !== prev_g1 ||
            m0_readdata !== (prev_g1 ? 32'hFFFFABCD : 32'hDEADBEEF)) begin
          tests_failed++; errs++;
          $display("[TB] FAIL contention_route[%0d]: got rdv0=%b rdv1=%b data=%h, expected rdv0=%b rdv1=%b",
                   i, m0_readdatavalid, m1_readdatavalid, m0_readdata, !prev_g1, prev_g1);
        end
      end
      if (m1_waitrequest === 1'b1) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      prev_g1 = exp_g1;
      step();
    end
    drive_idle();
    #2;
    tests_run++;
    if (m0_readdatavalid !== !prev_g1 || m1_readdatavalid !== prev_g1) begin
      tests_failed++;
      $display("[TB] FAIL contention_last_route: got rdv0=%b rdv1=%b, expected %b %b",
               m0_readdatavalid, m1_readdatavalid, !prev_g1, prev_g1);
    end
    tests_run++;
`ifdef MPSOC_MEM_ARB_RR_EN
    if (max_run != 1) begin
`else
    if (max_run != 4) begin
`endif
      tests_failed++;
      $display("[TB] FAIL m1_max_stall_run: got %0d", max_run);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    step();
    m0_read = 1'b1; m0_address = 11'h005;
    #2;
    tests_run++;
    if (m0_waitrequest !== 1'b0 || mem_chipselect !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_issue: got w0=%b cs=%b, expected 0 1", m0_waitrequest, mem_chipselect);
    end
    step();
    reset = 1'b1;
    m1_read = 1'b1; m1_address = 11'h7FF;
    #2;
    tests_run++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_drops_read: got rdv0=%b rdv1=%b w0=%b w1=%b, expected 0 0 1 1",
               m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest);
    end
    step();
    reset = 1'b0;
    #2;
    tests_run++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_contention: got rdv0=%b rdv1=%b w0=%b w1=%b, expected 0 0 0 1",
               m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest);
    end
    step();
    drive_idle();
    #2;
    tests_run++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || m1_readdatavalid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_read_return: got rdv0=%b data=%h rdv1=%b, expected 1 deadbeef 0",
               m0_readdatavalid, m0_readdata, m1_readdatavalid);
    end
    step();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_write_read();
    test_partial_write();
    test_single_master();
    test_contention();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mpsoc_mem_arbiter.md
MPSOC_MEM_ARBITER -- requirements
Module: mpsoc_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, memory word-address width (2048 words).
REQ-002 Parameter DATA_W, default 32, data width; BE_W = DATA_W/8.
REQ-003 Parameter HOLD_MAX, default 4, maximum consecutive grants to one master while the other is requesting.
REQ-004 Ports clk (in, 1, sole clock) and reset (in, 1); one clock domain; reset is synchronous and active-high.
REQ-005 Ports m0_address in ADDR_W, m0_byteenable in BE_W, m0_read in 1, m0_write in 1, m0_writedata in DATA_W: master 0 command.
REQ-006 Ports m0_readdata out DATA_W, m0_readdatavalid out 1, m0_waitrequest out 1: master 0 response.
REQ-007 Ports m1_* are identical to m0_* for master 1.
REQ-008 Ports mem_address out ADDR_W, mem_byteenable out BE_W, mem_chipselect out 1, mem_write out 1, mem_writedata out DATA_W, mem_clken out 1: single-port RAM command.
REQ-009 Port mem_readdata in DATA_W: RAM read data, valid 1 cycle after a read is issued.

Function
REQ-010 Request: mX_req = mX_read | mX_write; simultaneous mX_read and mX_write is illegal, and write wins.
REQ-011 Each cycle, at most one master is granted, combinationally from the current requests and the registered state.
REQ-012 Granted master drives mem_address/byteenable/writedata; mem_chipselect = granted request; mem_write = granted write; mem_clken = 1 except during reset.
REQ-013 mX_waitrequest = mX_req & ~grantX; a non-requesting master sees waitrequest 0.
REQ-014 Issue occurs when request & grant; the command is accepted in that cycle, with no extra wait cycle.
REQ-015 A read issue sets registered tag {rd_valid, rd_id} for the next cycle only.
REQ-016 The cycle after a read issue: m<rd_id>_readdatavalid = 1 and m<rd_id>_readdata = mem_readdata. Latency is exactly 1; reads are pipelined back-to-back at 1 per cycle.
REQ-017 mX_readdata is driven from mem_readdata; mX_readdatavalid = 0 when not tagged.
REQ-018 Registered state: last_grant (1 bit) and hold_cnt (clog2(HOLD_MAX+1) bits).
REQ-019 hold_cnt increments on each issue by the same master as last_grant; it resets to 1 on a grant switch and to 0 when no master is requesting.
REQ-020 If only one master requests, it is granted regardless of hold_cnt.
REQ-021 If both masters request and hold_cnt == HOLD_MAX, the other master is granted (anti-starvation override).
REQ-022 Otherwise, with both masters requesting, the policy follows REQ-027/028.
REQ-023 Idle cycle (no requests): last_grant is held and no mem access occurs.

Reset
REQ-024 While reset = 1: both waitrequest = 1, mem_chipselect = 0, mem_write = 0, mem_clken = 0, both readdatavalid = 0.
REQ-025 Reset clears last_grant to 1 (master 0 favoured first), hold_cnt to 0 and rd_valid to 0.
REQ-026 A read issued in the cycle before reset asserts produces no readdatavalid; the first post-reset cycle is idle-ready.

Configuration
REQ-027 With MPSOC_MEM_ARB_RR_EN defined: round-robin; under contention the master != last_grant wins (subject to REQ-021 hold).
REQ-028 Without MPSOC_MEM_ARB_RR_EN: fixed priority; master 0 wins contention except when REQ-021 forces master 1; HOLD_MAX still bounds starvation.

Structure
REQ-029 Package mpsoc_mem_arb_pkg holds master-ID type (1 bit), NUM_MASTERS = 2, default ADDR_W/DATA_W/HOLD_MAX constants.
REQ-030 One sub-module, mpsoc_arb_grant, holds the grant logic (requests, last_grant, hold_cnt -> one-hot grant); the datapath mux and read tag stay in the top.

Verification
REQ-031 m0 write addr 0x005 data 0xDEADBEEF be 0xF, then m0 read 0x005 -> m0_readdatavalid exactly 1 cycle later with 0xDEADBEEF; m1 sees no valid.
REQ-032 Both masters stream reads continuously, RR_EN defined -> grants alternate 0,1,0,1; each readdatavalid is routed to the correct master.
REQ-033 RR_EN undefined, HOLD_MAX = 4, both requesting -> m0 granted 4 cycles, m1 1 cycle, repeating; m1 waitrequest never high for more than 4 consecutive cycles.
REQ-034 m1 write 0x7FF be 0x3 data 0x0000ABCD over 0xFFFFFFFF -> read returns 0xFFFFABCD (address wrap at top word correct).
REQ-035 Reset asserted the cycle after an m0 read issue -> no readdatavalid, both waitrequest = 1 during reset, m0 wins the first contended cycle after reset.
